// File: rtl/multicycle_ctrl_if.sv
// Memory handshake between the multicycle controller (master) and the memory port (slave).
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_write;
  logic adr_src;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
  modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-style control FSM: fetch/decode/execute/memory/writeback sequencing,
// with illegal-instruction and memory-timeout traps that hold until reset.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned FULL_BRANCH = 1
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  mem,
  input  logic [6:0]         op,
  input  logic [2:0]         func3,
  input  logic [6:0]         func7,
  input  logic               zero,
  input  logic               negative,
  output logic               pc_en,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         alusrc_a,
  output logic [1:0]         alusrc_b,
  output logic [1:0]         result_src,
  output logic [2:0]         aluop,
  output logic [2:0]         imm_src,
  output logic [3:0]         state,
  output logic               illegal,
  output logic               timeout
);

  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_EX_R = 4'd2, S_EX_I = 4'd3, S_EX_ADDR = 4'd4,
    S_MEM_RD = 4'd5, S_MEM_WR = 4'd6, S_WB_ALU = 4'd7, S_WB_MEM = 4'd8,
    S_EX_JAL = 4'd9, S_EX_JALR = 4'd10, S_EX_BR = 4'd11, S_WB_LUI = 4'd12,
    S_TRAP = 4'd15
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                         ALU_OR = 3'b011, ALU_SLT = 3'b100, ALU_SLTU = 3'b101,
                         ALU_XOR = 3'b110;
  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b100;
  localparam logic [8:0] TMO_LIMIT = 9'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       illegal_q, illegal_d;
  logic       timeout_q, timeout_d;
  logic       mem_req_c, mem_write_c, adr_src_c;
  logic       waiting, taken, br_ok;

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    timeout_d   = timeout_q;
    pc_en       = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    alusrc_a    = 2'b00;
    alusrc_b    = 2'b00;
    result_src  = 2'b00;
    aluop       = ALU_ADD;
    imm_src     = IMM_I;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    adr_src_c   = 1'b0;
    taken       = 1'b0;
    br_ok       = 1'b1;

    unique case (state_q)
      S_IF: begin
        mem_req_c  = 1'b1;
        alusrc_b   = 2'b10;
        result_src = 2'b01;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_ID;
        end
      end
      S_ID: begin
        alusrc_a = 2'b01;
        alusrc_b = 2'b01;
        imm_src  = IMM_B;
        case (op)
          7'b0110011: state_d = S_EX_R;
          7'b0010011: state_d = S_EX_I;
          7'b0000011,
          7'b0100011: state_d = S_EX_ADDR;
          7'b1101111: state_d = S_EX_JAL;
          7'b1100111: state_d = S_EX_JALR;
          7'b1100011: state_d = S_EX_BR;
          7'b0110111: state_d = S_WB_LUI;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EX_R: begin
        alusrc_a = 2'b10;
        state_d  = S_WB_ALU;
        case ({func7, func3})
          {7'b0000000, 3'b000}: aluop = ALU_ADD;
          {7'b0100000, 3'b000}: aluop = ALU_SUB;
          {7'b0000000, 3'b010}: aluop = ALU_SLT;
          {7'b0000000, 3'b011}: aluop = ALU_SLTU;
          {7'b0000000, 3'b100}: aluop = ALU_XOR;
          {7'b0000000, 3'b110}: aluop = ALU_OR;
          {7'b0000000, 3'b111}: aluop = ALU_AND;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EX_I: begin
        alusrc_a = 2'b10;
        alusrc_b = 2'b01;
        imm_src  = IMM_I;
        state_d  = S_WB_ALU;
        case (func3)
          3'b000: aluop = ALU_ADD;
          3'b010: aluop = ALU_SLT;
          3'b011: aluop = ALU_SLTU;
          3'b100: aluop = ALU_XOR;
          3'b110: aluop = ALU_OR;
          3'b111: aluop = ALU_AND;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EX_ADDR: begin
        // op[5] separates store (0100011) from load (0000011)
        alusrc_a = 2'b10;
        alusrc_b = 2'b01;
        imm_src  = op[5] ? IMM_S : IMM_I;
        state_d  = op[5] ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (mem.mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
        if (mem.mem_ready) state_d = S_IF;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        state_d   = S_IF;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        result_src = 2'b10;
        state_d    = S_IF;
      end
      S_WB_LUI: begin
        reg_write  = 1'b1;
        result_src = 2'b11;
        imm_src    = IMM_U;
        state_d    = S_IF;
      end
      S_EX_JAL, S_EX_JALR: begin
        reg_write  = 1'b1;
        pc_en      = 1'b1;
        result_src = 2'b01;
        alusrc_a   = 2'b01;
        alusrc_b   = 2'b10;
        state_d    = S_IF;
      end
      S_EX_BR: begin
        alusrc_a = 2'b10;
        aluop    = ALU_SUB;
        case (func3)
          3'b000:  taken = zero;
          3'b001:  taken = !zero;
          3'b100:  taken = negative;
          3'b101:  taken = !negative;
          default: br_ok = 1'b0;
        endcase
        if (FULL_BRANCH == 0 && func3 != 3'b000) br_ok = 1'b0;
        if (br_ok) begin
          pc_en   = taken;
          state_d = S_IF;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    waiting = mem_req_c && !mem.mem_ready;
    if (waiting && ({1'b0, wait_cnt_q} + 9'd1 >= TMO_LIMIT)) begin
      state_d   = S_TRAP;
      timeout_d = 1'b1;
    end
    wait_cnt_d = (waiting && state_d == state_q) ? wait_cnt_q + 8'd1 : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IF;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mem.mem_req   = mem_req_c;
  assign mem.mem_write = mem_write_c;
  assign mem.adr_src   = adr_src_c;
  assign state         = state_q;
  assign illegal       = illegal_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: full-branch and beq-only builds run side by side.
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] op = '0, func7 = '0;
  logic [2:0] func3 = '0;
  logic       zero = 1'b0, negative = 1'b0;

  multicycle_ctrl_if mif ();
  multicycle_ctrl_if mif_nb ();

  logic       pc_en, ir_write, reg_write, illegal, timeout;
  logic [1:0] alusrc_a, alusrc_b, result_src;
  logic [2:0] aluop, imm_src;
  logic [3:0] state;
  logic       nb_pc_en, nb_ir_write, nb_reg_write, nb_illegal, nb_timeout;
  logic [1:0] nb_alusrc_a, nb_alusrc_b, nb_result_src;
  logic [2:0] nb_aluop, nb_imm_src;
  logic [3:0] nb_state;

  multicycle_ctrl #(.MEM_TIMEOUT(15), .FULL_BRANCH(1)) u_dut (
    .clk(clk), .rst(rst), .mem(mif), .op(op), .func3(func3), .func7(func7),
    .zero(zero), .negative(negative), .pc_en(pc_en), .ir_write(ir_write),
    .reg_write(reg_write), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b),
    .result_src(result_src), .aluop(aluop), .imm_src(imm_src), .state(state),
    .illegal(illegal), .timeout(timeout)
  );

  multicycle_ctrl #(.MEM_TIMEOUT(15), .FULL_BRANCH(0)) u_nb (
    .clk(clk), .rst(rst), .mem(mif_nb), .op(op), .func3(func3), .func7(func7),
    .zero(zero), .negative(negative), .pc_en(nb_pc_en), .ir_write(nb_ir_write),
    .reg_write(nb_reg_write), .alusrc_a(nb_alusrc_a), .alusrc_b(nb_alusrc_b),
    .result_src(nb_result_src), .aluop(nb_aluop), .imm_src(nb_imm_src), .state(nb_state),
    .illegal(nb_illegal), .timeout(nb_timeout)
  );

  localparam int OP_R = 'b0110011, OP_I = 'b0010011, OP_LD = 'b0000011, OP_ST = 'b0100011;
  localparam int OP_BR = 'b1100011, OP_JAL = 'b1101111, OP_LUI = 'b0110111, OP_BAD = 'b1111111;

  // strb packs {pc_en, ir_write, mem_req, mem_write, adr_src, reg_write}
  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z, n, rdy;
    logic [3:0] st, nst;
    logic [5:0] strb;
    logic [1:0] asa, asb, rsrc;
    logic [2:0] alu, imm;
    logic       ill, tmo, nbill;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t V(int r, int op_i, int f3, int f7, int z, int n, int rdy,
                             int st, int strb, int asa, int asb, int rsrc, int alu,
                             int imm, int ill, int tmo, int nbt);
    vec_t v;
    v.rst = 1'(r);   v.op = 7'(op_i); v.f3 = 3'(f3); v.f7 = 7'(f7);
    v.z = 1'(z);     v.n = 1'(n);     v.rdy = 1'(rdy);
    v.st = 4'(st);   v.strb = 6'(strb);
    v.asa = 2'(asa); v.asb = 2'(asb); v.rsrc = 2'(rsrc);
    v.alu = 3'(alu); v.imm = 3'(imm);
    v.ill = 1'(ill); v.tmo = 1'(tmo);
    v.nst = (nbt != 0) ? 4'd15 : 4'(st);
    v.nbill = 1'(nbt);
    return v;
  endfunction

  task automatic fetch(input int op_i, input int f3, input int f7, input int nbt);
    tbl.push_back(V(1, op_i, f3, f7, 0, 0, 1, 0, 'b111000, 0, 2, 1, 0, 0, 0, 0, nbt));
    tbl.push_back(V(1, op_i, f3, f7, 0, 0, 1, 1, 'b000000, 1, 1, 0, 0, 2, 0, 0, nbt));
  endtask

  task automatic reset_row();
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 'b001000, 0, 2, 1, 0, 0, 0, 0, 0));
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    rst = v.rst; op = v.op; func3 = v.f3; func7 = v.f7;
    zero = v.z; negative = v.n;
    mif.mem_ready = v.rdy; mif_nb.mem_ready = v.rdy;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk($sformatf("v%0d.state", idx), int'(state), int'(e.st));
    chk($sformatf("v%0d.strobes", idx),
        int'({pc_en, ir_write, mif.mem_req, mif.mem_write, mif.adr_src, reg_write}), int'(e.strb));
    chk($sformatf("v%0d.alusrc_a", idx), int'(alusrc_a), int'(e.asa));
    chk($sformatf("v%0d.alusrc_b", idx), int'(alusrc_b), int'(e.asb));
    chk($sformatf("v%0d.result_src", idx), int'(result_src), int'(e.rsrc));
    chk($sformatf("v%0d.aluop", idx), int'(aluop), int'(e.alu));
    chk($sformatf("v%0d.imm_src", idx), int'(imm_src), int'(e.imm));
    chk($sformatf("v%0d.illegal", idx), int'(illegal), int'(e.ill));
    chk($sformatf("v%0d.timeout", idx), int'(timeout), int'(e.tmo));
    chk($sformatf("v%0d.nb_state", idx), int'(nb_state), int'(e.nst));
    chk($sformatf("v%0d.nb_illegal", idx), int'(nb_illegal), int'(e.nbill));
    @(posedge clk);
    #1;
  endtask

  initial begin
    mif.mem_ready = 1'b0;
    mif_nb.mem_ready = 1'b0;

    reset_row();
    // add x3,x1,x2
    fetch(OP_R, 0, 0, 0);
    tbl.push_back(V(1, OP_R, 0, 0, 0, 0, 1, 2, 'b000000, 2, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, OP_R, 0, 0, 0, 0, 1, 7, 'b000001, 0, 0, 0, 0, 0, 0, 0, 0));
    // sub
    fetch(OP_R, 0, 'b0100000, 0);
    tbl.push_back(V(1, OP_R, 0, 'b0100000, 0, 0, 1, 2, 'b000000, 2, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(V(1, OP_R, 0, 'b0100000, 0, 0, 1, 7, 'b000001, 0, 0, 0, 0, 0, 0, 0, 0));
    // xor
    fetch(OP_R, 4, 0, 0);
    tbl.push_back(V(1, OP_R, 4, 0, 0, 0, 1, 2, 'b000000, 2, 0, 0, 6, 0, 0, 0, 0));
    tbl.push_back(V(1, OP_R, 4, 0, 0, 0, 1, 7, 'b000001, 0, 0, 0, 0, 0, 0, 0, 0));
    // slti: func7 is ignored for immediates
    fetch(OP_I, 2, 'b0100000, 0);
    tbl.push_back(V(1, OP_I, 2, 'b0100000, 0, 0, 1, 3, 'b000000, 2, 1, 0, 4, 0, 0, 0, 0));
    tbl.push_back(V(1, OP_I, 2, 'b0100000, 0, 0, 1, 7, 'b000001, 0, 0, 0, 0, 0, 0, 0, 0));
    // lw with three wait cycles in MEM_RD
    fetch(OP_LD, 2, 0, 0);
    tbl.push_back(V(1, OP_LD, 2, 0, 0, 0, 1, 4, 'b000000, 2, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(V(1, OP_LD, 2, 0, 0, 0, 0, 5, 'b001010, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, OP_LD, 2, 0, 0, 0, 1, 5, 'b001010, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, OP_LD, 2, 0, 0, 0, 1, 8, 'b000001, 0, 0, 2, 0, 0, 0, 0, 0));
    // lui, jal
    fetch(OP_LUI, 0, 0, 0);
    tbl.push_back(V(1, OP_LUI, 0, 0, 0, 0, 1, 12, 'b000001, 0, 0, 3, 0, 4, 0, 0, 0));
    fetch(OP_JAL, 0, 0, 0);
    tbl.push_back(V(1, OP_JAL, 0, 0, 0, 0, 1, 9, 'b100001, 1, 2, 1, 0, 0, 0, 0, 0));
    // bne taken; the beq-only build traps on it
    fetch(OP_BR, 1, 0, 0);
    tbl.push_back(V(1, OP_BR, 1, 0, 0, 0, 1, 11, 'b100000, 2, 0, 0, 1, 0, 0, 0, 0));
    // bne not taken, blt taken, bge not taken
    fetch(OP_BR, 1, 0, 1);
    tbl.push_back(V(1, OP_BR, 1, 0, 1, 0, 1, 11, 'b000000, 2, 0, 0, 1, 0, 0, 0, 1));
    fetch(OP_BR, 4, 0, 1);
    tbl.push_back(V(1, OP_BR, 4, 0, 0, 1, 1, 11, 'b100000, 2, 0, 0, 1, 0, 0, 0, 1));
    fetch(OP_BR, 5, 0, 1);
    tbl.push_back(V(1, OP_BR, 5, 0, 0, 1, 1, 11, 'b000000, 2, 0, 0, 1, 0, 0, 0, 1));
    // bltu encoding is illegal in both builds
    fetch(OP_BR, 6, 0, 1);
    tbl.push_back(V(1, OP_BR, 6, 0, 0, 0, 1, 11, 'b000000, 2, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(V(1, OP_BR, 6, 0, 0, 0, 1, 15, 'b000000, 0, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(V(1, OP_BR, 6, 0, 0, 0, 1, 15, 'b000000, 0, 0, 0, 0, 0, 1, 0, 1));
    reset_row();
    // sll is not supported
    fetch(OP_R, 1, 0, 0);
    tbl.push_back(V(1, OP_R, 1, 0, 0, 0, 1, 2, 'b000000, 2, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, OP_R, 1, 0, 0, 0, 1, 15, 'b000000, 0, 0, 0, 0, 0, 1, 0, 1));
    reset_row();
    // unknown opcode traps from ID
    fetch(OP_BAD, 0, 0, 0);
    tbl.push_back(V(1, OP_BAD, 0, 0, 0, 0, 1, 15, 'b000000, 0, 0, 0, 0, 0, 1, 0, 1));
    reset_row();
    // fetch timeout: 15 wait cycles then sticky trap
    for (int i = 0; i < 15; i++)
      tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, 0, 'b001000, 0, 2, 1, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, 15, 'b000000, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 1, 15, 'b000000, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 1, 15, 'b000000, 0, 0, 0, 0, 0, 0, 1, 0));
    reset_row();
    // sw into a stalled MEM_WR
    fetch(OP_ST, 2, 0, 0);
    tbl.push_back(V(1, OP_ST, 2, 0, 0, 0, 1, 4, 'b000000, 2, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(V(1, OP_ST, 2, 0, 0, 0, 0, 6, 'b001110, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) apply(tbl[i], i);

    // asynchronous reset in the middle of the stalled store
    #2;
    chk("mid_wr.state", int'(state), 6);
    chk("mid_wr.mem_write", int'(mif.mem_write), 1);
    rst = 1'b0;
    #1;
    chk("rst_async.state", int'(state), 0);
    chk("rst_async.mem_write", int'(mif.mem_write), 0);
    chk("rst_async.mem_req", int'(mif.mem_req), 1);
    chk("rst_async.flags", int'({illegal, timeout}), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mif.mem_ready = 1'b1;
    mif_nb.mem_ready = 1'b1;
    @(negedge clk);
    chk("post_rst.state", int'(state), 0);
    chk("post_rst.ir_write", int'(ir_write), 1);
    @(posedge clk);
    #1;
    chk("post_rst.to_id", int'(state), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
